// File: rtl/lsu_dmem_arbiter_if.sv
// Bundle between the two LSU lanes and the shared 1r1w data memory port.
//   master : lane/wrapper side - drives lane requests and flush, sees the
//            memory-side controls, read-valid steering, stall and error.
//   slave  : arbiter side - the reverse directions.
// Lane fields are packed [NUM_LANES-1:0][...], lane 0 being older in program order.
interface lsu_dmem_arbiter_if #(
  parameter int NUM_LANES     = 2,
  parameter int ADDR_W        = 32,
  parameter int MEM_DEPTH_BIT = 9,
  parameter int MEM_W         = 128
);
  logic                                flush;
  logic [NUM_LANES-1:0]                req_ren;
  logic [NUM_LANES-1:0]                req_wr;
  logic [NUM_LANES-1:0][ADDR_W-1:0]    req_addr;
  logic [NUM_LANES-1:0][MEM_W-1:0]     req_wen;
  logic [NUM_LANES-1:0][MEM_W-1:0]     req_wr_data;
  logic [MEM_DEPTH_BIT-1:0]            dmem_addr;
  logic                                dmem_ren;
  logic [MEM_W-1:0]                    dmem_wen;
  logic [MEM_W-1:0]                    dmem_wr_data;
  logic [NUM_LANES-1:0]                rd_vld;
  logic                                arb_stall;
  logic                                arb_err;

  modport master (
    output flush, req_ren, req_wr, req_addr, req_wen, req_wr_data,
    input  dmem_addr, dmem_ren, dmem_wen, dmem_wr_data, rd_vld, arb_stall, arb_err
  );
  modport slave (
    input  flush, req_ren, req_wr, req_addr, req_wen, req_wr_data,
    output dmem_addr, dmem_ren, dmem_wen, dmem_wr_data, rd_vld, arb_stall, arb_err
  );
endinterface

// File: rtl/lsu_dmem_arbiter.sv
// Arbiter for the single 1r1w data memory shared by LSU lanes 0 and 1.
// Both lanes may present a load or store in the same cycle; lane 0 is
// granted first and lane 1 is parked in a one-entry replay buffer that
// issues the following cycle while issue is stalled.
//
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset
//   bus    - lsu_dmem_arbiter_if.slave: lane requests, flush, memory-side
//            addr/ren/wen/wr_data, per-lane rd_vld, arb_stall, arb_err
//   perf_conflict_cnt / perf_load_cnt / perf_store_cnt
//          - 32-bit saturating event counters, present only when the
//            macro LSU_ARB_PERF_CNT_EN is defined.
//
// Memory-side outputs and arb_stall are combinational from the current
// requests (flow-through); rd_vld and arb_err are registered.

// Per-lane request decode.
module lsu_dmem_arb_lane #(
  parameter int ADDR_W        = 32,
  parameter int MEM_DEPTH_BIT = 9,
  parameter int MEM_WIDTH_BIT = 4
) (
  input  logic                     ren,
  input  logic                     wr,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     req,
  output logic                     st,
  output logic                     illegal,
  output logic [MEM_DEPTH_BIT-1:0] line
);
  assign req     = ren | wr;
  // ren+wr together is a protocol error; the op proceeds as a store
  assign st      = wr;
  assign illegal = ren & wr;
  assign line    = addr[MEM_DEPTH_BIT+MEM_WIDTH_BIT-1:MEM_WIDTH_BIT];

  // byte offset and upper address bits do not select a line
  logic unused_addr;
  assign unused_addr = ^{addr[ADDR_W-1:MEM_DEPTH_BIT+MEM_WIDTH_BIT], addr[MEM_WIDTH_BIT-1:0]};
endmodule

module lsu_dmem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int MEM_DEPTH_BIT = 9,
  parameter int MEM_WIDTH_BIT = 4,
  parameter int MEM_W         = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_dmem_arbiter_if.slave bus
`ifdef LSU_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_conflict_cnt,
  output logic [31:0] perf_load_cnt,
  output logic [31:0] perf_store_cnt
`endif
);
  localparam int NUM_LANES = 2;

  typedef enum logic {IDLE, REPLAY} state_t;

  typedef struct packed {
    logic                     st;
    logic [MEM_DEPTH_BIT-1:0] line;
    logic [MEM_W-1:0]         wen;
    logic [MEM_W-1:0]         data;
  } op_t;

  logic [NUM_LANES-1:0]                    req, st, illegal;
  logic [NUM_LANES-1:0][MEM_DEPTH_BIT-1:0] line;
  op_t  [NUM_LANES-1:0]                    lane_op;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_dmem_arb_lane #(
      .ADDR_W(ADDR_W), .MEM_DEPTH_BIT(MEM_DEPTH_BIT), .MEM_WIDTH_BIT(MEM_WIDTH_BIT)
    ) u_lane (
      .ren(bus.req_ren[i]), .wr(bus.req_wr[i]), .addr(bus.req_addr[i]),
      .req(req[i]), .st(st[i]), .illegal(illegal[i]), .line(line[i])
    );
    assign lane_op[i] = '{st: st[i], line: line[i], wen: bus.req_wen[i], data: bus.req_wr_data[i]};
  end

  state_t               state, nxt_state;
  op_t                  buf_op;
  op_t                  gnt;
  logic                 gnt_vld, gnt_lane, capture, conflict, stall, err_set, live;
  logic                 gnt_ld, gnt_st;
  logic [NUM_LANES-1:0] rd_vld_q;
  logic                 err_q;

  // reset and flush both squash the current cycle's grant
  assign live = rst_n & ~bus.flush;

  always_comb begin
    nxt_state = state;
    gnt       = '0;
    gnt_vld   = 1'b0;
    gnt_lane  = 1'b0;
    capture   = 1'b0;
    conflict  = 1'b0;
    stall     = 1'b0;
    err_set   = |illegal;
    case (state)
      IDLE: begin
        if (live) begin
          if (req[0]) begin
            gnt     = lane_op[0];
            gnt_vld = 1'b1;
            if (req[1]) begin
              // lane 1 parks in the buffer; IDU holds off one cycle
              capture   = 1'b1;
              conflict  = 1'b1;
              stall     = 1'b1;
              nxt_state = REPLAY;
            end
          end else if (req[1]) begin
            gnt      = lane_op[1];
            gnt_vld  = 1'b1;
            gnt_lane = 1'b1;
          end
        end
      end
      REPLAY: begin
        // issue was stalled, so any fresh request is a protocol breach and is dropped
        err_set   = err_set | (|req);
        nxt_state = IDLE;
        if (live) begin
          gnt      = buf_op;
          gnt_vld  = 1'b1;
          gnt_lane = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign gnt_ld = gnt_vld & ~gnt.st;
  assign gnt_st = gnt_vld &  gnt.st;

  assign bus.dmem_ren     = gnt_ld;
  assign bus.dmem_addr    = gnt_vld ? gnt.line : '0;
  assign bus.dmem_wen     = gnt_st  ? gnt.wen  : '0;
  assign bus.dmem_wr_data = gnt_st  ? gnt.data : '0;
  assign bus.arb_stall    = stall;
  assign bus.rd_vld       = rd_vld_q;
  assign bus.arb_err      = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      buf_op   <= '0;
      rd_vld_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= nxt_state;
      if (capture) buf_op <= lane_op[1];
      // memory read latency is one cycle; rd_vld lines up with rd_data
      rd_vld_q <= gnt_ld ? (NUM_LANES'(1) << gnt_lane) : '0;
      err_q    <= err_q | err_set;
    end
  end

`ifdef LSU_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_conflict_cnt <= '0;
      perf_load_cnt     <= '0;
      perf_store_cnt    <= '0;
    end else begin
      if (conflict && perf_conflict_cnt != '1) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (gnt_ld   && perf_load_cnt     != '1) perf_load_cnt     <= perf_load_cnt     + 32'd1;
      if (gnt_st   && perf_store_cnt    != '1) perf_store_cnt    <= perf_store_cnt    + 32'd1;
    end
  end
`endif
endmodule
